dly_path_monitor: RTL



---
 rtl/dly_path_monitor.sv | 111 +++++++++++
 1 files changed

// File: rtl/dly_path_monitor.sv
// Launch/capture companion for a chain of delay cells: toggles LAUNCH into the
// path, synchronises the far-end return and counts CLK cycles until it matches.
module dly_path_monitor #(
    parameter int CNT_W       = 8,
    parameter int MAX_CYC     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             RETURN_I,
    output logic             LAUNCH,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] COUNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYC);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   launch_q, launch_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   rs;
    logic                   settled;

    function automatic logic at_limit(input logic [CNT_W-1:0] c);
        return c == MAX_CNT;
    endfunction

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], RETURN_I};
    assign rs      = sync_q[SYNC_STAGES-1];
    assign settled = (rs == launch_q);

    // Arrival is tested before the limit so a return on the last cycle still wins.
    always_comb begin
        state_d   = state_q;
        launch_d  = launch_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (START && settled) begin
                    launch_d  = ~launch_q;
                    count_d   = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (settled) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else if (at_limit(count_q)) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_FIN;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= S_IDLE;
            sync_q    <= '0;
            launch_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            launch_q  <= launch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    assign LAUNCH  = launch_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign TIMEOUT = timeout_q;
    assign COUNT   = count_q;

endmodule
